// File: rtl/multi_cycle_result_buffer.sv
// Result FIFO for the mx5 multi-cycle pipe output: per-thread rollback kill, issue stall, overflow flag.
// Optional combinational empty-FIFO bypass selected by defining MX_RESULT_BYPASS_EN.
module multi_cycle_result_buffer #(
    parameter int LANES        = 16,
    parameter int THREAD_IDX_W = 2,
    parameter int SUBCYCLE_W   = 4,
    parameter int DEPTH        = 8,
    parameter int STALL_SLACK  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mx5_valid,
    input  logic [THREAD_IDX_W-1:0] mx5_thread_idx,
    input  logic [SUBCYCLE_W-1:0]   mx5_subcycle,
    input  logic [LANES-1:0]        mx5_mask_value,
    input  logic [4:0]              mx5_dest_reg,
    input  logic                    mx5_dest_vector,
    input  logic [32*LANES-1:0]     mx5_result,
    input  logic                    rollback_en,
    input  logic [THREAD_IDX_W-1:0] rollback_thread,
    input  logic                    wb_ready,
    output logic                    mxb_valid,
    output logic [THREAD_IDX_W-1:0] mxb_thread_idx,
    output logic [SUBCYCLE_W-1:0]   mxb_subcycle,
    output logic [LANES-1:0]        mxb_mask_value,
    output logic [4:0]              mxb_dest_reg,
    output logic                    mxb_dest_vector,
    output logic [32*LANES-1:0]     mxb_result,
    output logic                    mxb_stall,
    output logic                    mxb_overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - STALL_SLACK - 1);

    typedef struct packed {
        logic [THREAD_IDX_W-1:0] thread_idx;
        logic [SUBCYCLE_W-1:0]   subcycle;
        logic [LANES-1:0]        mask_value;
        logic [4:0]              dest_reg;
        logic                    dest_vector;
        logic [32*LANES-1:0]     result;
    } entry_t;

    entry_t           entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] kill_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             overflow_q;

    entry_t in_entry;
    entry_t head;
    entry_t out_entry;
    logic   in_kill;
    logic   head_valid;
    logic   head_kill;
    logic   full;
    logic   pop;
    logic   push;
    logic   drop;
`ifdef MX_RESULT_BYPASS_EN
    logic   bypass;
`endif

    always_comb begin
        in_entry = '{thread_idx:  mx5_thread_idx,
                     subcycle:    mx5_subcycle,
                     mask_value:  mx5_mask_value,
                     dest_reg:    mx5_dest_reg,
                     dest_vector: mx5_dest_vector,
                     result:      mx5_result};
    end

    assign in_kill    = rollback_en && (rollback_thread == mx5_thread_idx);
    assign head       = entries_q[rd_ptr_q];
    assign head_valid = valid_q[rd_ptr_q];
    assign head_kill  = kill_q[rd_ptr_q];
    assign full       = (count_q == FULL_CNT);
    // Killed heads drain unconditionally so they never block live results behind them.
    assign pop        = head_valid && (head_kill || wb_ready);
`ifdef MX_RESULT_BYPASS_EN
    assign bypass     = (count_q == '0) && mx5_valid && !in_kill;
    assign push       = mx5_valid && (!full || pop) && !(bypass && wb_ready);
`else
    assign push       = mx5_valid && (!full || pop);
`endif
    assign drop       = mx5_valid && full && !pop;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Write order matters: rollback marks, then pop clears, then push (which may reuse the popped slot when full).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= '0;
            kill_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[PTR_W'(i)] <= '0;
            end
        end else begin
            if (rollback_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (valid_q[PTR_W'(i)] && (entries_q[PTR_W'(i)].thread_idx == rollback_thread)) begin
                        kill_q[PTR_W'(i)] <= 1'b1;
                    end
                end
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                kill_q[rd_ptr_q]  <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                entries_q[wr_ptr_q] <= in_entry;
                valid_q[wr_ptr_q]   <= 1'b1;
                kill_q[wr_ptr_q]    <= in_kill;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            count_q <= count_nxt;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        out_entry = head;
        mxb_valid = head_valid && !head_kill;
`ifdef MX_RESULT_BYPASS_EN
        if (bypass) begin
            out_entry = in_entry;
            mxb_valid = 1'b1;
        end
`endif
    end

    assign mxb_thread_idx  = out_entry.thread_idx;
    assign mxb_subcycle    = out_entry.subcycle;
    assign mxb_mask_value  = out_entry.mask_value;
    assign mxb_dest_reg    = out_entry.dest_reg;
    assign mxb_dest_vector = out_entry.dest_vector;
    assign mxb_result      = out_entry.result;
    assign mxb_stall       = (count_q > STALL_TH);
    assign mxb_overflow    = overflow_q;

endmodule

// File: tb/tb_multi_cycle_result_buffer.sv
// Directed, table-driven bench for multi_cycle_result_buffer (default build; bypass build checked where noted).
module tb_multi_cycle_result_buffer;
    localparam int LANES = 16;
    localparam int FW    = 2 + 4 + LANES + 5 + 1 + 32 * LANES;

    logic                  clk;
    logic                  reset_n;
    logic                  mx5_valid;
    logic [1:0]            mx5_thread_idx;
    logic [3:0]            mx5_subcycle;
    logic [LANES-1:0]      mx5_mask_value;
    logic [4:0]            mx5_dest_reg;
    logic                  mx5_dest_vector;
    logic [32*LANES-1:0]   mx5_result;
    logic                  rollback_en;
    logic [1:0]            rollback_thread;
    logic                  wb_ready;
    logic                  mxb_valid;
    logic [1:0]            mxb_thread_idx;
    logic [3:0]            mxb_subcycle;
    logic [LANES-1:0]      mxb_mask_value;
    logic [4:0]            mxb_dest_reg;
    logic                  mxb_dest_vector;
    logic [32*LANES-1:0]   mxb_result;
    logic                  mxb_stall;
    logic                  mxb_overflow;

    int checks = 0;
    int errors = 0;

    multi_cycle_result_buffer #(
        .LANES(LANES), .THREAD_IDX_W(2), .SUBCYCLE_W(4), .DEPTH(8), .STALL_SLACK(5)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .mx5_valid(mx5_valid), .mx5_thread_idx(mx5_thread_idx), .mx5_subcycle(mx5_subcycle),
        .mx5_mask_value(mx5_mask_value), .mx5_dest_reg(mx5_dest_reg), .mx5_dest_vector(mx5_dest_vector),
        .mx5_result(mx5_result), .rollback_en(rollback_en), .rollback_thread(rollback_thread),
        .wb_ready(wb_ready), .mxb_valid(mxb_valid), .mxb_thread_idx(mxb_thread_idx),
        .mxb_subcycle(mxb_subcycle), .mxb_mask_value(mxb_mask_value), .mxb_dest_reg(mxb_dest_reg),
        .mxb_dest_vector(mxb_dest_vector), .mxb_result(mxb_result), .mxb_stall(mxb_stall),
        .mxb_overflow(mxb_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        bit          v;
        logic [1:0]  thr;
        logic [31:0] w;
        bit          wb;
        bit          rb;
        logic [1:0]  rbt;
        bit          ev;
        logic [1:0]  et;
        logic [31:0] ew;
        bit          es;
        bit          eo;
        int          ec;
    } vec_t;

    function automatic vec_t mk(bit v, int thr, logic [31:0] w, bit wb, bit rb, int rbt,
                                bit ev, int et, logic [31:0] ew, bit es, bit eo, int ec);
        vec_t t;
        t.v = v; t.thr = 2'(thr); t.w = w; t.wb = wb; t.rb = rb; t.rbt = 2'(rbt);
        t.ev = ev; t.et = 2'(et); t.ew = ew; t.es = es; t.eo = eo; t.ec = ec;
        return t;
    endfunction

    function automatic logic [FW-1:0] exp_fields(logic [1:0] thr, logic [31:0] w);
        return {thr, w[3:0], w[15:0], w[4:0], w[0], {LANES{w}}};
    endfunction

    function automatic logic [FW-1:0] act_fields();
        return {mxb_thread_idx, mxb_subcycle, mxb_mask_value, mxb_dest_reg, mxb_dest_vector, mxb_result};
    endfunction

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] thr, input logic [31:0] w);
        mx5_valid       = v;
        mx5_thread_idx  = thr;
        mx5_subcycle    = w[3:0];
        mx5_mask_value  = w[15:0];
        mx5_dest_reg    = w[4:0];
        mx5_dest_vector = w[0];
        mx5_result      = {LANES{w}};
    endtask

    task automatic check_state(input string tag, input bit ev, input logic [1:0] et, input logic [31:0] ew,
                               input bit es, input bit eo, input int ec);
        chk({tag, " valid"}, 640'(mxb_valid), 640'(ev));
        if (ev) chk({tag, " fields"}, 640'(act_fields()), 640'(exp_fields(et, ew)));
        chk({tag, " stall"}, 640'(mxb_stall), 640'(es));
        chk({tag, " overflow"}, 640'(mxb_overflow), 640'(eo));
        chk({tag, " count"}, 640'(dut.count_q), 640'(ec));
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        drive(t.v, t.thr, t.w);
        wb_ready        = t.wb;
        rollback_en     = t.rb;
        rollback_thread = t.rbt;
        @(posedge clk);
        #1;
        mx5_valid   = 1'b0;
        rollback_en = 1'b0;
        check_state(tag, t.ev, t.et, t.ew, t.es, t.eo, t.ec);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 32'h0);
        wb_ready = 1'b0; rollback_en = 1'b0; rollback_thread = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_state(tag, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 0);
        chk({tag, " data zero"}, 640'(act_fields()), 640'(0));
    endtask

    vec_t vecs[$];

    initial begin
        // Fill with wb_ready low, overflow on the ninth push, then drain in order.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, k % 4, 32'h4000_0000 + k, 0, 0, 0, 1, 0, 32'h4000_0000, k >= 2, 0, k + 1));
        vecs.push_back(mk(1, 0, 32'hdead_beef, 0, 0, 0, 1, 0, 32'h4000_0000, 1, 1, 8));
        for (int j = 0; j < 8; j++)
            vecs.push_back(mk(0, 0, 32'h0, 1, 0, 0, j < 7, (j + 1) % 4, 32'h4000_0001 + j, (7 - j) >= 3, 1, 7 - j));

        do_reset("reset");

        // Single result, thread 1, writeback ready.
        drive(1'b1, 2'd1, 32'h3f80_0000);
        wb_ready = 1'b1;
        #1;
`ifdef MX_RESULT_BYPASS_EN
        chk("single pre-edge valid", 640'(mxb_valid), 640'(1));
        chk("single pre-edge fields", 640'(act_fields()), 640'(exp_fields(2'd1, 32'h3f80_0000)));
        @(posedge clk);
        #1;
        mx5_valid = 1'b0;
        check_state("single post-edge", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 0);
`else
        chk("single pre-edge valid", 640'(mxb_valid), 640'(0));
        @(posedge clk);
        #1;
        mx5_valid = 1'b0;
        check_state("single post-edge", 1'b1, 2'd1, 32'h3f80_0000, 1'b0, 1'b0, 1);
`endif
        run_vec(mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0), "single drained");

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("tbl%0d", i));

        // Rollback of thread 0, including a same-cycle incoming thread-0 result.
        do_reset("reset2");
        run_vec(mk(1, 0, 32'h5000_0000, 0, 0, 0, 1, 0, 32'h5000_0000, 0, 0, 1), "rb push0");
        run_vec(mk(1, 1, 32'h5000_0001, 0, 0, 0, 1, 0, 32'h5000_0000, 0, 0, 2), "rb push1");
        run_vec(mk(1, 0, 32'h5000_0002, 0, 0, 0, 1, 0, 32'h5000_0000, 1, 0, 3), "rb push2");
        run_vec(mk(1, 2, 32'h5000_0003, 0, 0, 0, 1, 0, 32'h5000_0000, 1, 0, 4), "rb push3");
        run_vec(mk(1, 0, 32'h5000_0004, 0, 1, 0, 0, 0, 32'h0, 1, 0, 5), "rb kill");
        run_vec(mk(0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h5000_0001, 1, 0, 4), "rb drain0");
        run_vec(mk(0, 0, 32'h0, 0, 0, 0, 1, 1, 32'h5000_0001, 1, 0, 4), "rb hold1");
        run_vec(mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 1, 0, 3), "rb take1");
        run_vec(mk(0, 0, 32'h0, 0, 0, 0, 1, 2, 32'h5000_0003, 0, 0, 2), "rb drain2");
        run_vec(mk(0, 0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0, 0, 1), "rb take3");
        run_vec(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0), "rb drain4");

        // Full FIFO accepting a push in the same cycle as a pop.
        do_reset("reset3");
        for (int k = 0; k < 8; k++)
            run_vec(mk(1, k % 4, 32'h6000_0000 + k, 0, 0, 0, 1, 0, 32'h6000_0000, k >= 2, 0, k + 1),
                    $sformatf("full push%0d", k));
        run_vec(mk(1, 0, 32'h6000_0008, 1, 0, 0, 1, 1, 32'h6000_0001, 1, 0, 8), "full push+pop");
        for (int j = 0; j < 8; j++)
            run_vec(mk(0, 0, 32'h0, 1, 0, 0, j < 7, (j + 2) % 4, 32'h6000_0002 + j, (7 - j) >= 3, 0, 7 - j),
                    $sformatf("full drain%0d", j));

        // Asynchronous reset while four results are held.
        do_reset("reset4");
        for (int k = 0; k < 4; k++)
            run_vec(mk(1, k, 32'h7000_0000 + k, 0, 0, 0, 1, 0, 32'h7000_0000, k >= 2, 0, k + 1),
                    $sformatf("mid push%0d", k));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async valid", 640'(mxb_valid), 640'(0));
        chk("async stall", 640'(mxb_stall), 640'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("after release", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
